// File: rtl/lab3_dg_scanctrl.sv
// Keypad digit history with time-multiplexed display scan.
// Newest key code lives in digit 0; each digit is enabled for DWELL clocks in turn.
module lab3_dg_scanctrl #(
    parameter int               NUM_DIGITS = 2,
    parameter int               KEY_W      = 8,
    parameter int               DWELL      = 24000,
    parameter logic [KEY_W-1:0] BLANK_CODE = '0
) (
    input  logic                          int_osc,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [KEY_W-1:0]              key_code,
    input  logic                          clear,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic [KEY_W-1:0]              digit_data,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [KEY_W-1:0]      code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] valid;
    logic                  key_prev;
    logic                  capture;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;

    assign capture = key_valid & ~key_prev;

    // Edge register updates even under clear so a held key is not re-captured.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            key_prev <= 1'b0;
        end else begin
            key_prev <= key_valid;
        end
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) code[i] <= '0;
            valid <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) code[i] <= '0;
            valid <= '0;
        end else if (capture) begin
            code[0] <= key_code;
            for (int i = 1; i < NUM_DIGITS; i++) code[i] <= code[i-1];
            valid <= {valid[NUM_DIGITS-2:0], 1'b1};
        end
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Explicit per-digit compare keeps digit_en one-hot for non-power-of-two counts.
    always_comb begin
        digit_en   = '0;
        digit_data = BLANK_CODE;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_en[i] = 1'b1;
                digit_data  = valid[i] ? code[i] : BLANK_CODE;
            end
        end
    end

    assign digit_idx = idx;

endmodule
